config_readback_uart_tx: RTL
============================

// Module: config_readback_uart_tx
// PURPOSE
//  Return path of the UART configuration port: serialises 32-bit configuration readback words onto a UART Tx line (8N1).
//  Words come from the frame readback logic (frame data register / ConfigFSM side) through a valid/ready handshake.
//  Each word is sent as 4 bytes, most significant byte first.
//  Sits beside config_UART in Config and shares CLK/resetn with it; host tools pair it with the existing UART receive path.
// PARAMETERS
//  ClkDiv    434  CLK cycles per UART bit period (50 MHz / 115200); legal range 2..65535
//  CntWidth  16   width of the bit-period counter; must hold ClkDiv-1
// PORTS
//  CLK        in   1   system clock; all logic on rising edge
//  resetn     in   1   asynchronous, active-low reset
//  ReadData   in   32  readback word, sampled only on acceptance
//  ReadStrobe in   1   ReadData valid
//  ReadReady  out  1   block can accept a word this cycle
//  Tx         out  1   UART serial output, idle high
//  TxActive   out  1   high while a word is being transmitted
//  TxLED      out  1   toggles once per completed word
// BEHAVIOUR
//  Reset (async assert, sync release): Tx=1, ReadReady=1, TxActive=0, TxLED=0.
//  - Also clears FSM=IDLE, bit counter, byte index and shift register.
//  Handshake: word accepted on a CLK edge where ReadStrobe && ReadReady.
//  - ReadData is latched into a 32-bit holding register at acceptance.
//  - ReadReady is high only in IDLE; it drops on the cycle after acceptance.
//  - ReadStrobe while ReadReady=0 is ignored; no queueing, no error flag.
//  FSM states: IDLE, START, DATA, STOP.
//  IDLE: Tx=1. On acceptance -> START, byte index=0, bit counter=0.
//  START: Tx=0 for ClkDiv cycles, then -> DATA with bit index=0.
//  DATA: Tx = current byte bit[bit index], LSB first, ClkDiv cycles per bit.
//  - After bit 7 -> STOP.
//  STOP: Tx=1 for ClkDiv cycles. Then:
//  - if byte index<3: byte index+1, -> START;
//  - else -> IDLE and TxLED toggles.
//  Byte order: byte0=[31:24], byte1=[23:16], byte2=[15:8], byte3=[7:0].
//  Timing:
//  - Tx falls on the first edge after the acceptance edge (1-cycle latency).
//  - One word occupies exactly 40*ClkDiv cycles of line time.
//  - ReadReady returns high on the cycle after the final stop bit ends.
//  Back-to-back: a word accepted on the first IDLE cycle gives a 1-cycle gap (Tx=1) between words; this is the minimum.
//  Bit counter: counts 0..ClkDiv-1, then wraps to 0 and advances the bit/state. No other modulo arithmetic is used.
//  TxActive = (state != IDLE); it is registered together with the state.
//  Reset mid-transfer: Tx goes high immediately (async). The partial word is dropped and is not resent.
//  Tx is driven directly from a flop (no combinational glitches on the line).
// TESTING
//  1 Reset: hold resetn=0 with ReadStrobe=1 -> Tx=1, ReadReady=1, TxActive=0, TxLED=0; no word accepted.
//  2 ClkDiv=4, send 0xA5C30F81.
//    -> line carries bytes A5,C3,0F,81, each start/LSB-first/stop, 4 cycles per bit.
//    -> 160 cycles of line time in total; TxLED toggles once; ReadReady high on cycle 161.
//  3 Back-to-back: ReadStrobe held high with 0x00000001 then 0xFFFFFFFF.
//    -> second word accepted on the first IDLE cycle; exactly 1 idle-high cycle between words.
//  4 Busy: pulse ReadStrobe with 0xDEADBEEF mid-word -> ignored; line data of the word in flight unchanged.
//  5 Reset asserted during bit 3 of byte1 -> Tx=1 that cycle.
//    -> after release, a new word 0x12345678 transmits correctly from byte0.
//  6 ClkDiv=2 boundary: send 0x80000000 -> every bit lasts exactly 2 cycles; first data bit of byte0 is 0, eighth is 1.

Source files
------------

// File: rtl/config_readback_uart_tx.sv
// Serialises 32-bit configuration readback words onto an 8N1 UART Tx line.
// Each word is sent as four bytes, MSB byte first and LSB bit first, with Tx driven from a flop.
module config_readback_uart_tx #(
    parameter int ClkDiv   = 434,
    parameter int CntWidth = 16
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic [31:0] ReadData,
    input  logic        ReadStrobe,
    output logic        ReadReady,
    output logic        Tx,
    output logic        TxActive,
    output logic        TxLED
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState;

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(ClkDiv - 1);

    txState              state, stateNext;
    logic [CntWidth-1:0] bitCnt, bitCntNext;
    logic [2:0]          bitIdx, bitIdxNext;
    logic [1:0]          byteIdx, byteIdxNext;
    logic [31:0]         holdReg, holdNext;
    logic [7:0]          shiftReg, shiftNext;
    logic                ledNext;
    logic                txNext;
    logic                activeNext;

    assign ReadReady = (state == IDLE);

    // State register: Tx and TxActive are registered from next-state values,
    // so the line changes on the same edge as the state it belongs to.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            byteIdx  <= '0;
            holdReg  <= '0;
            shiftReg <= '0;
            Tx       <= 1'b1;
            TxActive <= 1'b0;
            TxLED    <= 1'b0;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            bitIdx   <= bitIdxNext;
            byteIdx  <= byteIdxNext;
            holdReg  <= holdNext;
            shiftReg <= shiftNext;
            Tx       <= txNext;
            TxActive <= activeNext;
            TxLED    <= ledNext;
        end
    end

    // Next-state logic; the holding register shifts left one byte per STOP,
    // so the byte about to be sent is always holdReg[31:24].
    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        bitIdxNext  = bitIdx;
        byteIdxNext = byteIdx;
        holdNext    = holdReg;
        shiftNext   = shiftReg;
        ledNext     = TxLED;
        unique case (state)
            IDLE: begin
                if (ReadStrobe) begin
                    stateNext   = START;
                    holdNext    = ReadData;
                    byteIdxNext = 2'd0;
                    bitCntNext  = '0;
                end
            end
            START: begin
                if (bitCnt == CntLast) begin
                    bitCntNext = '0;
                    bitIdxNext = 3'd0;
                    shiftNext  = holdReg[31:24];
                    stateNext  = DATA;
                end else begin
                    bitCntNext = bitCnt + 1'b1;
                end
            end
            DATA: begin
                if (bitCnt == CntLast) begin
                    bitCntNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                        shiftNext  = {1'b0, shiftReg[7:1]};
                    end
                end else begin
                    bitCntNext = bitCnt + 1'b1;
                end
            end
            STOP: begin
                if (bitCnt == CntLast) begin
                    bitCntNext = '0;
                    if (byteIdx == 2'd3) begin
                        stateNext = IDLE;
                        ledNext   = ~TxLED;
                    end else begin
                        byteIdxNext = byteIdx + 2'd1;
                        holdNext    = {holdReg[23:0], 8'h00};
                        stateNext   = START;
                    end
                end else begin
                    bitCntNext = bitCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: values the output flops take on the coming edge.
    always_comb begin
        txNext     = 1'b1;
        activeNext = (stateNext != IDLE);
        unique case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftNext[0];
            default: txNext = 1'b1;
        endcase
    end

endmodule
